// File: rtl/zynq_axil_csr_responder.sv
// AXI4-Lite subordinate terminating a GP port: a bank of RW control registers
// plus read-only status words, one outstanding write and one outstanding read.
module zynq_axil_csr_responder #(
  parameter int addr_width_p = 10,
  parameter int data_width_p = 32,
  parameter int num_rw_p     = 8,
  parameter int num_ro_p     = 4
) (
  input  logic                             clk_i,
  input  logic                             reset_i,
  input  logic [addr_width_p-1:0]          awaddr_i,
  input  logic [2:0]                       awprot_i,
  input  logic                             awvalid_i,
  output logic                             awready_o,
  input  logic [data_width_p-1:0]          wdata_i,
  input  logic [data_width_p/8-1:0]        wstrb_i,
  input  logic                             wvalid_i,
  output logic                             wready_o,
  output logic [1:0]                       bresp_o,
  output logic                             bvalid_o,
  input  logic                             bready_i,
  input  logic [addr_width_p-1:0]          araddr_i,
  input  logic [2:0]                       arprot_i,
  input  logic                             arvalid_i,
  output logic                             arready_o,
  output logic [data_width_p-1:0]          rdata_o,
  output logic [1:0]                       rresp_o,
  output logic                             rvalid_o,
  input  logic                             rready_i,
  output logic [num_rw_p*data_width_p-1:0] csr_data_o,
  output logic [num_rw_p-1:0]              csr_w_v_o,
  input  logic [num_ro_p*data_width_p-1:0] status_i
);
  localparam int strb_w_lp = data_width_p / 8;
  localparam int off_w_lp  = $clog2(strb_w_lp);
  localparam int idx_w_lp  = addr_width_p - off_w_lp;
  localparam logic [1:0] resp_okay_lp   = 2'b00;
  localparam logic [1:0] resp_slverr_lp = 2'b10;

  logic [data_width_p-1:0] regs_q [num_rw_p];
  logic [data_width_p-1:0] regs_d [num_rw_p];
  logic                    aw_full_q, aw_full_d, w_full_q, w_full_d;
  logic [addr_width_p-1:0] awaddr_q, awaddr_d;
  logic [data_width_p-1:0] wdata_q, wdata_d;
  logic [strb_w_lp-1:0]    wstrb_q, wstrb_d;
  logic                    bvalid_q, bvalid_d, rvalid_q, rvalid_d;
  logic [1:0]              bresp_q, bresp_d, rresp_q, rresp_d;
  logic [data_width_p-1:0] rdata_q, rdata_d;
  logic [num_rw_p-1:0]     wv_q, wv_d;

  logic                    aw_hs, w_hs, ar_hs, commit;
  logic [addr_width_p-1:0] c_addr;
  logic [data_width_p-1:0] c_data;
  logic [strb_w_lp-1:0]    c_strb;
  logic [idx_w_lp-1:0]     c_idx, r_idx;

  function automatic logic [data_width_p-1:0] merge_bytes(
    input logic [data_width_p-1:0] old_val,
    input logic [data_width_p-1:0] new_val,
    input logic [strb_w_lp-1:0]    strb);
    logic [data_width_p-1:0] res;
    res = old_val;
    for (int b = 0; b < strb_w_lp; b++)
      if (strb[b]) res[b*8 +: 8] = new_val[b*8 +: 8];
    return res;
  endfunction

  assign awready_o = ~aw_full_q & ~bvalid_q & ~reset_i;
  assign wready_o  = ~w_full_q & ~bvalid_q & ~reset_i;
  assign arready_o = ~rvalid_q & ~reset_i;
  assign aw_hs     = awvalid_i & awready_o;
  assign w_hs      = wvalid_i & wready_o;
  assign ar_hs     = arvalid_i & arready_o;

  // A same-cycle handshake counts as captured, so commit can bypass the flags
  assign commit = (aw_full_q | aw_hs) & (w_full_q | w_hs);
  assign c_addr = aw_full_q ? awaddr_q : awaddr_i;
  assign c_data = w_full_q ? wdata_q : wdata_i;
  assign c_strb = w_full_q ? wstrb_q : wstrb_i;
  assign c_idx  = c_addr[addr_width_p-1:off_w_lp];
  assign r_idx  = araddr_i[addr_width_p-1:off_w_lp];

  always_comb begin
    regs_d    = regs_q;
    aw_full_d = aw_full_q | aw_hs;
    awaddr_d  = aw_hs ? awaddr_i : awaddr_q;
    w_full_d  = w_full_q | w_hs;
    wdata_d   = w_hs ? wdata_i : wdata_q;
    wstrb_d   = w_hs ? wstrb_i : wstrb_q;
    bvalid_d  = bvalid_q & ~bready_i;
    bresp_d   = bresp_q;
    wv_d      = '0;
    if (commit) begin
      aw_full_d = 1'b0;
      w_full_d  = 1'b0;
      bvalid_d  = 1'b1;
      bresp_d   = resp_slverr_lp;
      for (int k = 0; k < num_rw_p; k++) begin
        if (c_idx == idx_w_lp'(k)) begin
          bresp_d   = resp_okay_lp;
          wv_d[k]   = 1'b1;
          regs_d[k] = merge_bytes(regs_q[k], c_data, c_strb);
        end
      end
    end
    rvalid_d = rvalid_q & ~rready_i;
    rdata_d  = rdata_q;
    rresp_d  = rresp_q;
    // Reads see regs_q, i.e. the value before any write committing this edge
    if (ar_hs) begin
      rvalid_d = 1'b1;
      rdata_d  = '0;
      rresp_d  = resp_slverr_lp;
      for (int k = 0; k < num_rw_p; k++) begin
        if (r_idx == idx_w_lp'(k)) begin
          rdata_d = regs_q[k];
          rresp_d = resp_okay_lp;
        end
      end
      for (int j = 0; j < num_ro_p; j++) begin
        if (r_idx == idx_w_lp'(num_rw_p + j)) begin
          rdata_d = status_i[j*data_width_p +: data_width_p];
          rresp_d = resp_okay_lp;
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      for (int k = 0; k < num_rw_p; k++) regs_q[k] <= '0;
      aw_full_q <= 1'b0;
      w_full_q  <= 1'b0;
      bvalid_q  <= 1'b0;
      bresp_q   <= 2'b00;
      rvalid_q  <= 1'b0;
      rresp_q   <= 2'b00;
      rdata_q   <= '0;
      wv_q      <= '0;
    end else begin
      regs_q    <= regs_d;
      aw_full_q <= aw_full_d;
      w_full_q  <= w_full_d;
      bvalid_q  <= bvalid_d;
      bresp_q   <= bresp_d;
      rvalid_q  <= rvalid_d;
      rresp_q   <= rresp_d;
      rdata_q   <= rdata_d;
      wv_q      <= wv_d;
    end
  end

  // Capture payloads are qualified by the flags, so they need no reset
  always_ff @(posedge clk_i) begin
    awaddr_q <= awaddr_d;
    wdata_q  <= wdata_d;
    wstrb_q  <= wstrb_d;
  end

  for (genvar k = 0; k < num_rw_p; k++) begin : g_csr
    assign csr_data_o[k*data_width_p +: data_width_p] = regs_q[k];
  end

  assign bvalid_o  = bvalid_q;
  assign bresp_o   = bresp_q;
  assign rvalid_o  = rvalid_q;
  assign rresp_o   = rresp_q;
  assign rdata_o   = rdata_q;
  assign csr_w_v_o = wv_q;

  logic unused_bits;
  assign unused_bits = ^{awprot_i, arprot_i, c_addr[off_w_lp-1:0], araddr_i[off_w_lp-1:0]};

`ifndef SYNTHESIS
  assert property (@(posedge clk_i) disable iff (reset_i)
    (bvalid_o && !bready_i) |=> (bvalid_o && $stable(bresp_o)));
  assert property (@(posedge clk_i) disable iff (reset_i)
    (rvalid_o && !rready_i) |=> (rvalid_o && $stable(rdata_o) && $stable(rresp_o)));
  assert property (@(posedge clk_i) (data_width_p == 32) || (data_width_p == 64));
`endif
endmodule
